sfx_player: RTL and testbench
=============================

Name: sfx_player

Overview:
- Sound-effect sequencer sitting directly upstream of the audio codec controller.
- Turns per-player fire events into a timed square-wave tone burst.
- Drives left/right sample words plus a write strobe qualified by the controller's ready flag.
- Replaces the free-running tone toggle and duration counter in the top level. Each player gets a distinct pitch.

Parameters:
- HALF1, 56818: tone half-period in Clk cycles for player-1 shots (440 Hz at 50 MHz).
- HALF2, 45455: tone half-period in Clk cycles for player-2 shots (550 Hz at 50 MHz).
- DURATION, 3000000: burst length in Clk cycles (60 ms).
- AMPL, 20000000: sample value when the wave is high; the low level is 0.
- SWEEP_INT, 100000: Clk cycles between pitch steps (used only with the optional feature).
- SWEEP_STEP, 256: half-period increment per pitch step (used only with the optional feature).

Ports:
- Clk  in  1  system clock, 50 MHz
- Reset  in  1  synchronous, active-high reset
- fire1  in  1  player-1 fire request, level; rising edge triggers
- fire2  in  1  player-2 fire request, level; rising edge triggers
- cd1  in  1  player-1 cooldown active; suppresses fire1 triggers
- cd2  in  1  player-2 cooldown active; suppresses fire2 triggers
- audio_out_allowed  in  1  codec controller can accept a sample this cycle
- LDATA  out  32  left-channel sample
- RDATA  out  32  right-channel sample, always equal to LDATA
- write_audio_out  out  1  sample write strobe
- playing  out  1  burst in progress
- src  out  1  source of the current or last burst: 0 = player 1, 1 = player 2

Behaviour:
- One clock. Reset is synchronous and active-high; clock port is Clk, reset port is Reset.
- Reset values:
  - state = IDLE, playing = 0, write_audio_out = 0, LDATA = RDATA = 0, src = 0.
  - All counters = 0; wave level = 0.
  - Edge registers f1_q and f2_q load the current fire1/fire2 values, so a level already held high through reset does not trigger.
- Trigger detection:
  - t1 = fire1 & ~f1_q & ~cd1
  - t2 = fire2 & ~f2_q & ~cd2
  - f1_q and f2_q register fire1 and fire2 every cycle.
- Simultaneous t1 and t2: t1 wins (src = 0, HALF1); t2 is dropped.
- State machine, two states:
  - IDLE -> PLAY on t1|t2. In the same edge: half_cnt = 0, dur_cnt = 0, wave level = 1, cur_half = the selected HALFx, src updated.
  - PLAY -> PLAY on a new trigger (retrigger). Counters reload exactly as on entry; the new source wins, with the same t1 priority.
  - PLAY -> IDLE when dur_cnt == DURATION-1 and no trigger is present that cycle. Level is forced to 0 on exit.
  - Trigger on the same cycle as expiry: retrigger takes precedence and the state stays PLAY.
- Tone generation in PLAY:
  - half_cnt increments each cycle.
  - When half_cnt == cur_half-1: half_cnt wraps to 0 and the level toggles.
  - half_cnt is 20 bits, dur_cnt is 25 bits; both are unsigned.
- Outputs:
  - LDATA = RDATA = (playing & level) ? AMPL : 0.
  - playing = (state == PLAY).
  - write_audio_out = playing & audio_out_allowed, combinational.
  - No buffering: a sample the codec does not accept is simply skipped.
- Latency: the trigger edge is sampled on cycle N; playing = 1, LDATA = AMPL and strobes become valid from cycle N+1.
- Reset mid-burst: the next edge returns to IDLE with every output at its reset value.

Optional Feature:
- Macro: SFX_SWEEP_EN.
- Defined:
  - A sweep counter (17 bits) runs while in PLAY and wraps every SWEEP_INT cycles.
  - At each wrap, cur_half += SWEEP_STEP, saturating at 2^20-1, giving a falling-pitch "pew".
  - The sweep counter reloads to 0 on every trigger.
- Undefined: cur_half is constant for the whole burst and no sweep logic is synthesized.

Test Plan:
1. Reset held 3 cycles with fire1 = 1, then fire1 kept high -> no burst; playing = 0, LDATA = 0, write_audio_out = 0.
2. fire1 rising edge, cd1 = 0, audio_out_allowed = 1, small parameters (HALF1 = 4, DURATION = 20) -> playing high for exactly 20 cycles; LDATA toggles AMPL/0 every 4 cycles starting with AMPL; src = 0; then IDLE.
3. fire1 and fire2 rise on the same cycle -> src = 0 and player-1 period used. fire2 edge while cd2 = 1 -> ignored.
4. fire2 edge at dur_cnt = 15 of a player-1 burst (DURATION = 20) -> src = 1, period switches to HALF2, burst runs 20 further cycles. Edge exactly on the expiry cycle -> playing never drops.
5. audio_out_allowed toggling 1,0,1,0 during a burst -> write_audio_out follows it exactly; no strobe while IDLE. Reset asserted mid-burst -> all outputs 0 next cycle.
6. With SFX_SWEEP_EN (HALF1 = 4, SWEEP_INT = 10, SWEEP_STEP = 2) -> period 4, then 6 after 10 cycles, then 8 after 20. Without the macro -> period stays 4.

Source files
------------

// File: rtl/sfx_player.sv
// Sound-effect sequencer: per-player fire edges start a timed square-wave burst toward the codec.
// Optional falling-pitch sweep is compiled in with `define SFX_SWEEP_EN.
module sfx_player #(
  parameter int unsigned HALF1    = 56818,
  parameter int unsigned HALF2    = 45455,
  parameter int unsigned DURATION = 3000000,
  parameter logic [31:0] AMPL     = 32'd20000000
`ifdef SFX_SWEEP_EN
  ,
  parameter int unsigned SWEEP_INT  = 100000,
  parameter int unsigned SWEEP_STEP = 256
`endif
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        fire1,
  input  logic        fire2,
  input  logic        cd1,
  input  logic        cd2,
  input  logic        audio_out_allowed,
  output logic [31:0] LDATA,
  output logic [31:0] RDATA,
  output logic        write_audio_out,
  output logic        playing,
  output logic        src
);

  typedef enum logic {IDLE = 1'b0, PLAY = 1'b1} state_t;

  localparam logic [19:0] HALF1_W  = 20'(HALF1);
  localparam logic [19:0] HALF2_W  = 20'(HALF2);
  localparam logic [24:0] DUR_LAST = 25'(DURATION - 1);

  state_t      state_q, state_d;
  logic        f1_q, f1_d;
  logic        f2_q, f2_d;
  logic [19:0] half_cnt_q, half_cnt_d;
  logic [24:0] dur_cnt_q, dur_cnt_d;
  logic [19:0] cur_half_q, cur_half_d;
  logic        level_q, level_d;
  logic        src_q, src_d;
  logic        t1, t2, trig;
  logic [19:0] half_last;

`ifdef SFX_SWEEP_EN
  localparam logic [16:0] SWEEP_LAST = 17'(SWEEP_INT - 1);
  logic [16:0] sweep_cnt_q, sweep_cnt_d;
  logic [20:0] half_sum;
  assign half_sum = {1'b0, cur_half_q} + 21'(SWEEP_STEP);
`endif

  assign t1        = fire1 & ~f1_q & ~cd1;
  assign t2        = fire2 & ~f2_q & ~cd2;
  assign trig      = t1 | t2;
  assign half_last = cur_half_q - 20'd1;

  always_comb begin
    f1_d       = fire1;
    f2_d       = fire2;
    state_d    = state_q;
    half_cnt_d = half_cnt_q;
    dur_cnt_d  = dur_cnt_q;
    cur_half_d = cur_half_q;
    level_d    = level_q;
    src_d      = src_q;
`ifdef SFX_SWEEP_EN
    sweep_cnt_d = sweep_cnt_q;
`endif
    // A trigger (re)starts the burst from either state; player 1 wins ties.
    if (trig) begin
      state_d    = PLAY;
      half_cnt_d = '0;
      dur_cnt_d  = '0;
      level_d    = 1'b1;
      cur_half_d = t1 ? HALF1_W : HALF2_W;
      src_d      = ~t1;
`ifdef SFX_SWEEP_EN
      sweep_cnt_d = '0;
`endif
    end else if (state_q == PLAY) begin
      if (dur_cnt_q == DUR_LAST) begin
        state_d    = IDLE;
        level_d    = 1'b0;
        half_cnt_d = '0;
        dur_cnt_d  = '0;
      end else begin
        dur_cnt_d = dur_cnt_q + 25'd1;
        if (half_cnt_q == half_last) begin
          half_cnt_d = '0;
          level_d    = ~level_q;
        end else begin
          half_cnt_d = half_cnt_q + 20'd1;
        end
`ifdef SFX_SWEEP_EN
        if (sweep_cnt_q == SWEEP_LAST) begin
          sweep_cnt_d = '0;
          cur_half_d  = half_sum[20] ? 20'hFFFFF : half_sum[19:0];
        end else begin
          sweep_cnt_d = sweep_cnt_q + 17'd1;
        end
`endif
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= IDLE;
      f1_q       <= fire1;
      f2_q       <= fire2;
      half_cnt_q <= '0;
      dur_cnt_q  <= '0;
      cur_half_q <= '0;
      level_q    <= 1'b0;
      src_q      <= 1'b0;
`ifdef SFX_SWEEP_EN
      sweep_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      f1_q       <= f1_d;
      f2_q       <= f2_d;
      half_cnt_q <= half_cnt_d;
      dur_cnt_q  <= dur_cnt_d;
      cur_half_q <= cur_half_d;
      level_q    <= level_d;
      src_q      <= src_d;
`ifdef SFX_SWEEP_EN
      sweep_cnt_q <= sweep_cnt_d;
`endif
    end
  end

  assign playing         = (state_q == PLAY);
  assign LDATA           = (playing && level_q) ? AMPL : 32'd0;
  assign RDATA           = LDATA;
  assign write_audio_out = playing & audio_out_allowed;
  assign src             = src_q;

endmodule

// File: tb/tb_sfx_player.sv
// Directed bench for sfx_player with shrunk periods (HALF1=4, HALF2=3, DURATION=20).
module tb_sfx_player;
  localparam logic [31:0] AMP = 32'd20000000;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        fire1, fire2, cd1, cd2, audio_out_allowed;
  logic [31:0] LDATA, RDATA;
  logic        write_audio_out, playing, src;

  int total  = 0;
  int passed = 0;

  sfx_player #(
    .HALF1(4), .HALF2(3), .DURATION(20), .AMPL(AMP)
`ifdef SFX_SWEEP_EN
    , .SWEEP_INT(10), .SWEEP_STEP(2)
`endif
  ) dut (
    .Clk(Clk), .Reset(Reset), .fire1(fire1), .fire2(fire2), .cd1(cd1), .cd2(cd2),
    .audio_out_allowed(audio_out_allowed), .LDATA(LDATA), .RDATA(RDATA),
    .write_audio_out(write_audio_out), .playing(playing), .src(src)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 40 && playing; i++) tick();
    chk(tag, {31'd0, playing}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: fire1 held high through reset must not trigger
    Reset = 1'b1; fire1 = 1'b1; fire2 = 1'b0; cd1 = 1'b0; cd2 = 1'b0; audio_out_allowed = 1'b1;
    tick(); tick(); tick();
    chk("rst_playing", {31'd0, playing}, 32'd0);
    chk("rst_ldata", LDATA, 32'd0);
    chk("rst_rdata", RDATA, 32'd0);
    chk("rst_write", {31'd0, write_audio_out}, 32'd0);
    chk("rst_src", {31'd0, src}, 32'd0);
    Reset = 1'b0;
    tick(); tick();
    chk("held_fire_playing", {31'd0, playing}, 32'd0);
    chk("held_fire_ldata", LDATA, 32'd0);
    fire1 = 1'b0;
    tick();

    // 2: basic player-1 burst, 20 cycles, toggling every 4
    fire1 = 1'b1;
    tick();
    fire1 = 1'b0;
    for (int k = 0; k < 20; k++) begin
      chk($sformatf("p1_playing_k%0d", k), {31'd0, playing}, 32'd1);
      chk($sformatf("p1_ldata_k%0d", k), LDATA, ((k / 4) % 2 == 0) ? AMP : 32'd0);
      chk($sformatf("p1_rdata_k%0d", k), RDATA, ((k / 4) % 2 == 0) ? AMP : 32'd0);
      chk($sformatf("p1_src_k%0d", k), {31'd0, src}, 32'd0);
      tick();
    end
    chk("p1_end_playing", {31'd0, playing}, 32'd0);
    chk("p1_end_ldata", LDATA, 32'd0);
    chk("p1_end_write", {31'd0, write_audio_out}, 32'd0);

    // 3: simultaneous edges -> player 1 with HALF1; cooldown suppresses fire2
    fire1 = 1'b1; fire2 = 1'b1;
    tick();
    fire1 = 1'b0; fire2 = 1'b0;
    chk("sim_src", {31'd0, src}, 32'd0);
    tick(); tick(); tick();
    chk("sim_ldata_k3", LDATA, AMP);
    tick();
    chk("sim_ldata_k4", LDATA, 32'd0);
    wait_idle("sim_idle");
    cd2 = 1'b1; fire2 = 1'b1;
    tick();
    chk("cd2_playing", {31'd0, playing}, 32'd0);
    tick();
    cd2 = 1'b0;
    tick();
    chk("cd2_release_playing", {31'd0, playing}, 32'd0);
    fire2 = 1'b0;
    cd1 = 1'b1; fire1 = 1'b1;
    tick();
    chk("cd1_playing", {31'd0, playing}, 32'd0);
    cd1 = 1'b0; fire1 = 1'b0;
    tick();

    // 4: player-2 retrigger at dur_cnt 15, then retrigger on the expiry cycle
    fire1 = 1'b1;
    tick();
    fire1 = 1'b0;
    for (int k = 0; k < 15; k++) tick();
    chk("rt_k15_playing", {31'd0, playing}, 32'd1);
    fire2 = 1'b1;
    tick();
    fire2 = 1'b0;
    chk("rt_src", {31'd0, src}, 32'd1);
    for (int k = 0; k < 20; k++) begin
      chk($sformatf("rt_playing_k%0d", k), {31'd0, playing}, 32'd1);
      chk($sformatf("rt_ldata_k%0d", k), LDATA, ((k / 3) % 2 == 0) ? AMP : 32'd0);
      tick();
    end
    chk("rt_end_playing", {31'd0, playing}, 32'd0);
    fire1 = 1'b1;
    tick();
    fire1 = 1'b0;
    for (int k = 0; k < 19; k++) tick();
    chk("exp_k19_playing", {31'd0, playing}, 32'd1);
    chk("exp_k19_ldata", LDATA, AMP);
    fire2 = 1'b1;
    tick();
    fire2 = 1'b0;
    chk("exp_rt_playing", {31'd0, playing}, 32'd1);
    chk("exp_rt_src", {31'd0, src}, 32'd1);
    chk("exp_rt_ldata", LDATA, AMP);
    wait_idle("exp_idle");

    // 5: strobe follows audio_out_allowed; reset mid-burst clears everything
    fire1 = 1'b1;
    tick();
    fire1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      audio_out_allowed = (i % 2 == 0);
      #1;
      chk($sformatf("wr_follow_%0d", i), {31'd0, write_audio_out}, (i % 2 == 0) ? 32'd1 : 32'd0);
      tick();
    end
    audio_out_allowed = 1'b1;
    wait_idle("wr_idle");
    #1;
    chk("wr_idle_strobe", {31'd0, write_audio_out}, 32'd0);
    fire2 = 1'b1;
    tick();
    fire2 = 1'b0;
    tick();
    chk("mid_src_before", {31'd0, src}, 32'd1);
    Reset = 1'b1;
    tick();
    chk("mid_rst_playing", {31'd0, playing}, 32'd0);
    chk("mid_rst_ldata", LDATA, 32'd0);
    chk("mid_rst_write", {31'd0, write_audio_out}, 32'd0);
    chk("mid_rst_src", {31'd0, src}, 32'd0);
    Reset = 1'b0;
    tick();

    // 6: sweep stretches the half-period from 4 to 6 after 10 cycles
    fire1 = 1'b1;
    tick();
    fire1 = 1'b0;
    for (int k = 0; k < 20; k++) begin
`ifdef SFX_SWEEP_EN
      chk($sformatf("sweep_ldata_k%0d", k), LDATA, (k < 4 || (k >= 8 && k < 14)) ? AMP : 32'd0);
`else
      chk($sformatf("nosweep_ldata_k%0d", k), LDATA, ((k / 4) % 2 == 0) ? AMP : 32'd0);
`endif
      tick();
    end
    chk("sweep_end_playing", {31'd0, playing}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
